// File: rtl/knn_stream_classifier_pkg.sv
// Shared types and width helpers for the streaming KNN top-K classifier.
package knn_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_VOTE    = 2'd1,
        ST_RESULT  = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Counter must reach MAX_ELEMENTS+1 so overflow is observable before saturation.
    function automatic int cnt_width(input int max_elements);
        return clog2(max_elements + 2);
    endfunction

    function automatic int vote_width(input int k);
        return clog2(k + 1);
    endfunction

    localparam logic [63:0] DIST_INF = '1;

endpackage

// File: rtl/knn_stream_classifier_if.sv
// Sample input and result output handshakes of the KNN classifier.
interface knn_stream_classifier_if #(
    parameter int W      = 16,
    parameter int TYPE_W = 3,
    parameter int K      = 5
);
    localparam int VOTE_W = knn_pkg::vote_width(K);

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_distance;
    logic [TYPE_W-1:0] in_type;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [TYPE_W-1:0] out_type;
    logic [VOTE_W-1:0] out_votes;
    logic [W-1:0]      out_min_distance;
    logic              out_overflow;

    modport master (
        output in_valid, in_distance, in_type, in_last, out_ready,
        input  in_ready, out_valid, out_type, out_votes, out_min_distance, out_overflow
    );

    modport slave (
        input  in_valid, in_distance, in_type, in_last, out_ready,
        output in_ready, out_valid, out_type, out_votes, out_min_distance, out_overflow
    );

endinterface

// File: rtl/knn_topk_insert.sv
// K-slot sorted shift-insert buffer; slot 0 holds the nearest sample.
module knn_topk_insert
    import knn_pkg::*;
#(
    parameter int W      = 16,
    parameter int TYPE_W = 3,
    parameter int K      = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                insert_i,
    input  logic [W-1:0]        dist_i,
    input  logic [TYPE_W-1:0]   type_i,
    output logic [K*TYPE_W-1:0] types_o,
    output logic [K-1:0]        valid_o,
    output logic [W-1:0]        dist0_o
);

    logic [W-1:0]      dist_q [K];
    logic [W-1:0]      dist_d [K];
    logic [TYPE_W-1:0] type_q [K];
    logic [TYPE_W-1:0] type_d [K];
    logic [K-1:0]      vld_q, vld_d;
    logic [K-1:0]      gt;

    always_comb begin
        dist_d = dist_q;
        type_d = type_q;
        vld_d  = vld_q;
        // Strictly-greater compare keeps ties in arrival order; empty slots act as infinity.
        for (int k = 0; k < K; k++) begin
            gt[k] = !vld_q[k] || (dist_q[k] > dist_i);
        end
        if (flush_i) begin
            vld_d = '0;
            for (int k = 0; k < K; k++) begin
                dist_d[k] = DIST_INF[W-1:0];
            end
        end else if (insert_i) begin
            if (gt[0]) begin
                dist_d[0] = dist_i;
                type_d[0] = type_i;
                vld_d[0]  = 1'b1;
            end
            for (int k = 1; k < K; k++) begin
                if (gt[k]) begin
                    if (gt[k-1]) begin
                        dist_d[k] = dist_q[k-1];
                        type_d[k] = type_q[k-1];
                        vld_d[k]  = vld_q[k-1];
                    end else begin
                        dist_d[k] = dist_i;
                        type_d[k] = type_i;
                        vld_d[k]  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < K; k++) begin
                dist_q[k] <= DIST_INF[W-1:0];
                type_q[k] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            dist_q <= dist_d;
            type_q <= type_d;
        end
    end

    always_comb begin
        types_o = '0;
        for (int k = 0; k < K; k++) begin
            types_o[k*TYPE_W +: TYPE_W] = type_q[k];
        end
    end

    assign valid_o = vld_q;
    assign dist0_o = dist_q[0];

endmodule

// File: rtl/knn_stream_classifier.sv
// Streaming top-K selector with K-cycle majority vote over the nearest samples.
// state   | meaning
// COLLECT | accept samples, insert into sorted buffer
// VOTE    | scan slot idx, one per cycle, update per-class counts
// RESULT  | hold result until consumed or cleared
module knn_stream_classifier
    import knn_pkg::*;
#(
    parameter int W            = 16,
    parameter int TYPE_W       = 3,
    parameter int K            = 5,
    parameter int MAX_ELEMENTS = 1024
) (
    input logic                    clk,
    input logic                    rst,
    input logic                    clear,
    knn_stream_classifier_if.slave bus
);

    localparam int NCLS   = 1 << TYPE_W;
    localparam int CNT_W  = cnt_width(MAX_ELEMENTS);
    localparam int VOTE_W = vote_width(K);

    state_e            state_q, state_d;
    logic [VOTE_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [VOTE_W-1:0] vote_q [NCLS];
    logic [VOTE_W-1:0] vote_d [NCLS];
    logic [TYPE_W-1:0] best_type_q, best_type_d;
    logic [VOTE_W-1:0] best_cnt_q, best_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [TYPE_W-1:0] out_type_q, out_type_d;
    logic [VOTE_W-1:0] out_votes_q, out_votes_d;
    logic [W-1:0]      out_min_q, out_min_d;
    logic              out_ovf_q, out_ovf_d;

    logic [K*TYPE_W-1:0] slot_types;
    logic [K-1:0]        slot_valid;
    logic [W-1:0]        slot0_dist;
    logic                in_ready_w, accept, flush;
    logic [TYPE_W-1:0]   sel_type;
    logic                sel_vld;
    logic [VOTE_W-1:0]   inc;

    assign in_ready_w = (state_q == ST_COLLECT) && !rst;
    assign accept     = bus.in_valid && in_ready_w;
    assign flush      = clear || ((state_q == ST_RESULT) && bus.out_ready);

    knn_topk_insert #(.W(W), .TYPE_W(TYPE_W), .K(K)) u_topk (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush),
        .insert_i (accept && !clear),
        .dist_i   (bus.in_distance),
        .type_i   (bus.in_type),
        .types_o  (slot_types),
        .valid_o  (slot_valid),
        .dist0_o  (slot0_dist)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        vote_d      = vote_q;
        best_type_d = best_type_q;
        best_cnt_d  = best_cnt_q;
        out_valid_d = out_valid_q;
        out_type_d  = out_type_q;
        out_votes_d = out_votes_q;
        out_min_d   = out_min_q;
        out_ovf_d   = out_ovf_q;
        sel_type    = '0;
        sel_vld     = 1'b0;
        for (int k = 0; k < K; k++) begin
            if (idx_q == VOTE_W'(k)) begin
                sel_type = slot_types[k*TYPE_W +: TYPE_W];
                sel_vld  = slot_valid[k];
            end
        end
        inc = vote_q[sel_type] + VOTE_W'(1);

        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q >= CNT_W'(MAX_ELEMENTS)) ovf_d = 1'b1;
                    if (bus.in_last) begin
                        state_d     = ST_VOTE;
                        idx_d       = '0;
                        best_type_d = '0;
                        best_cnt_d  = '0;
                        for (int c = 0; c < NCLS; c++) vote_d[c] = '0;
                    end
                end
            end
            ST_VOTE: begin
                if (sel_vld) begin
                    vote_d[sel_type] = inc;
                    // Strict compare: the class that first reached the maximum keeps it.
                    if (inc > best_cnt_q) begin
                        best_type_d = sel_type;
                        best_cnt_d  = inc;
                    end
                end
                if (idx_q == VOTE_W'(K - 1)) begin
                    state_d     = ST_RESULT;
                    out_valid_d = 1'b1;
                    out_type_d  = best_type_d;
                    out_votes_d = best_cnt_d;
                    out_min_d   = slot0_dist;
                    out_ovf_d   = ovf_q;
                end else begin
                    idx_d = idx_q + VOTE_W'(1);
                end
            end
            ST_RESULT: ;
            default: state_d = ST_COLLECT;
        endcase

        if (flush) begin
            state_d     = ST_COLLECT;
            idx_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            best_type_d = '0;
            best_cnt_d  = '0;
            out_valid_d = 1'b0;
            out_type_d  = '0;
            out_votes_d = '0;
            out_min_d   = '0;
            out_ovf_d   = 1'b0;
            for (int c = 0; c < NCLS; c++) vote_d[c] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            idx_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            best_type_q <= '0;
            best_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_type_q  <= '0;
            out_votes_q <= '0;
            out_min_q   <= '0;
            out_ovf_q   <= 1'b0;
            for (int c = 0; c < NCLS; c++) vote_q[c] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            best_type_q <= best_type_d;
            best_cnt_q  <= best_cnt_d;
            out_valid_q <= out_valid_d;
            out_type_q  <= out_type_d;
            out_votes_q <= out_votes_d;
            out_min_q   <= out_min_d;
            out_ovf_q   <= out_ovf_d;
            vote_q      <= vote_d;
        end
    end

    assign bus.in_ready         = in_ready_w;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_type         = out_type_q;
    assign bus.out_votes        = out_votes_q;
    assign bus.out_min_distance = out_min_q;
    assign bus.out_overflow     = out_ovf_q;

endmodule

// File: tb/tb_knn_stream_classifier.sv
// Bench for knn_stream_classifier: directed and random queries against a sort-and-vote model.
module tb_knn_stream_classifier;
    import knn_pkg::*;

    localparam int W      = 16;
    localparam int TYPE_W = 3;
    localparam int K      = 5;
    localparam int MAXE   = 8;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    knn_stream_classifier_if #(.W(W), .TYPE_W(TYPE_W), .K(K)) bus ();

    knn_stream_classifier #(.W(W), .TYPE_W(TYPE_W), .K(K), .MAX_ELEMENTS(MAXE)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int q_d[$];
    int q_t[$];
    int exp_type, exp_votes, exp_min;
    int exp_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: stable selection of the K nearest over the whole query, then nearest-first vote.
    task automatic model();
        int  n;
        bit  taken[64];
        int  cnt[8];
        int  best_c;
        n = q_d.size();
        best_c = 0;
        exp_type = 0;
        exp_min = 0;
        foreach (taken[i]) taken[i] = 1'b0;
        foreach (cnt[i]) cnt[i] = 0;
        for (int s = 0; s < K; s++) begin
            int pick;
            pick = -1;
            for (int j = 0; j < n; j++) begin
                if (!taken[j] && (pick < 0 || q_d[j] < q_d[pick])) pick = j;
            end
            if (pick >= 0) begin
                taken[pick] = 1'b1;
                if (s == 0) exp_min = q_d[pick];
                cnt[q_t[pick]]++;
                if (cnt[q_t[pick]] > best_c) begin
                    best_c   = cnt[q_t[pick]];
                    exp_type = q_t[pick];
                end
            end
        end
        exp_votes = best_c;
        exp_ovf   = (n > MAXE) ? 1 : 0;
    endtask

    task automatic push(input int d, input int t, input bit last);
        @(negedge clk);
        check("in_ready_collect", 32'(bus.in_ready), 1);
        bus.in_valid    = 1'b1;
        bus.in_distance = 16'(d);
        bus.in_type     = 3'(t);
        bus.in_last     = last;
        @(posedge clk);
    endtask

    task automatic send_and_wait(input string tag);
        int lat;
        model();
        for (int i = 0; i < q_d.size(); i++) push(q_d[i], q_t[i], i == q_d.size() - 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check({tag, "_in_ready_low"}, 32'(bus.in_ready), 0);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.out_valid) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'(K));
        check({tag, "_type"}, 32'(bus.out_type), 32'(exp_type));
        check({tag, "_votes"}, 32'(bus.out_votes), 32'(exp_votes));
        check({tag, "_min"}, 32'(bus.out_min_distance), 32'(exp_min));
        check({tag, "_ovf"}, 32'(bus.out_overflow), 32'(exp_ovf));
    endtask

    task automatic hold_result(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            // Offered samples must be ignored while the result is pending.
            bus.in_valid    = 1'b1;
            bus.in_last     = 1'b1;
            bus.in_distance = 16'(0);
            bus.in_type     = 3'(7);
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 1);
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 0);
            check({tag, "_hold_type"}, 32'(bus.out_type), 32'(exp_type));
            check({tag, "_hold_min"}, 32'(bus.out_min_distance), 32'(exp_min));
        end
    endtask

    task automatic accept_result(input string tag);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_post_in_ready"}, 32'(bus.in_ready), 1);
        q_d.delete();
        q_t.delete();
    endtask

    task automatic run_query(input string tag, input int hold);
        send_and_wait(tag);
        hold_result(tag, hold);
        accept_result(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        check({tag, "_type"}, 32'(bus.out_type), 0);
        check({tag, "_votes"}, 32'(bus.out_votes), 0);
        check({tag, "_min"}, 32'(bus.out_min_distance), 0);
        check({tag, "_ovf"}, 32'(bus.out_overflow), 0);
    endtask

    task automatic fill_random(input int n);
        q_d.delete();
        q_t.delete();
        for (int i = 0; i < n; i++) begin
            q_d.push_back(int'($urandom_range(0, 40)));
            q_t.push_back(int'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_distance = '0;
        bus.in_type     = '0;
        bus.in_last     = 1'b0;
        bus.out_ready   = 1'b0;

        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_in_ready", 32'(bus.in_ready), 1);

        // Basic vote
        q_d = '{40, 10, 30, 20, 50, 5};
        q_t = '{1, 2, 2, 1, 3, 2};
        send_and_wait("basic");
        check("basic_type_const", 32'(bus.out_type), 2);
        check("basic_votes_const", 32'(bus.out_votes), 3);
        accept_result("basic");

        // Distance ties keep arrival order; sixth sample discarded
        q_d = '{10, 10, 10, 10, 10, 10};
        q_t = '{1, 2, 3, 4, 5, 6};
        send_and_wait("tie");
        check("tie_type_const", 32'(bus.out_type), 1);
        check("tie_votes_const", 32'(bus.out_votes), 1);
        accept_result("tie");

        // Short query with empty slots
        q_d = '{7, 9};
        q_t = '{4, 4};
        send_and_wait("short");
        check("short_votes_const", 32'(bus.out_votes), 2);
        accept_result("short");

        // Overflow boundaries
        fill_random(10);
        run_query("ovf10", 0);
        fill_random(MAXE);
        run_query("ovf_exact", 0);
        fill_random(MAXE + 1);
        run_query("ovf_plus1", 0);
        fill_random(3);
        run_query("ovf_next", 0);

        // Back-pressure, then clear instead of consuming
        q_d = '{12, 3, 25};
        q_t = '{6, 6, 1};
        send_and_wait("bp");
        hold_result("bp", 20);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("bp_clear_valid", 32'(bus.out_valid), 0);
        check("bp_clear_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        clear = 1'b0;
        q_d.delete();
        q_t.delete();

        // Clear mid-collect must discard buffered samples and win over a same-cycle transfer
        push(0, 7, 1'b0);
        push(1, 7, 1'b0);
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.in_distance = 16'(0);
        bus.in_type     = 3'(7);
        bus.in_last     = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("clear_collect_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        q_d = '{30, 31, 32};
        q_t = '{3, 3, 5};
        run_query("after_clear", 1);

        // Async reset mid-VOTE
        q_d = '{8, 4, 6};
        q_t = '{2, 2, 0};
        model();
        for (int i = 0; i < q_d.size(); i++) push(q_d[i], q_t[i], i == q_d.size() - 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_vote");
        @(negedge clk);
        rst = 1'b0;
        q_d.delete();
        q_t.delete();
        q_d = '{15, 11, 19, 2};
        q_t = '{5, 0, 5, 0};
        run_query("after_rst_vote", 0);

        // Async reset while the result is pending
        fill_random(4);
        send_and_wait("rst_result");
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_result");
        @(negedge clk);
        rst = 1'b0;
        q_d.delete();
        q_t.delete();

        // Random queries
        for (int r = 0; r < 30; r++) begin
            fill_random(int'($urandom_range(1, 11)));
            run_query("rand", int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/knn_stream_classifier.md
# knn_stream_classifier

Streaming top-K selector and majority-vote classifier for the KNN datapath, placed between `distance_calculator` and the result interface. It accepts one (distance, type) pair per cycle over a valid/ready handshake and keeps the K smallest distances in a sorted insertion buffer, so there is no fixed power-of-two batch or separate sort pass. On the last sample of a query it runs a K-cycle vote and presents the inferred type, vote count, nearest distance and an overflow flag over a valid/ready output.

## Interface
- `W`, 16: distance width.
- `TYPE_W`, 3: class label width; number of classes is 2^TYPE_W.
- `K`, 5: neighbours kept and voted; legal range is 1..64.
- `MAX_ELEMENTS`, 1024: samples allowed per query before overflow.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clear` input 1: synchronous abort. Returns the block to COLLECT and empties the buffer.
- `in_valid` input 1: sample valid.
- `in_ready` output 1: block accepts a sample.
- `in_distance` input W: sample distance; smaller means nearer.
- `in_type` input TYPE_W: sample label.
- `in_last` input 1: final sample of the query.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_type` output TYPE_W: inferred class.
- `out_votes` output clog2(K+1): votes for `out_type`.
- `out_min_distance` output W: nearest distance.
- `out_overflow` output 1: the query exceeded MAX_ELEMENTS samples.

## Operation
- States are COLLECT, VOTE and RESULT. `rst` forces COLLECT, an empty buffer and zeroed counters.
- **COLLECT:**
  - `in_ready`=1.
  - A transfer happens when `in_valid` and `in_ready` are both high.
  - Each transfer inserts the sample into the sorted K-slot buffer in one cycle. Slot 0 is the nearest.
  - A sample goes before the first slot whose distance is strictly greater. Ties therefore keep arrival order, with the earlier sample nearer.
  - The farthest entry drops out when the buffer is full.
  - A sample not smaller than slot K-1 of a full buffer is discarded.
  - Each slot carries a valid bit. Empty slots are treated as infinitely far and never vote.
- **Sample counter:** saturating, clog2(MAX_ELEMENTS+2) bits. When more than MAX_ELEMENTS samples are accepted, the sticky overflow bit is set. Samples are still processed after overflow.
- **Transfer with `in_last`:** the sample is inserted and the state moves to VOTE. Per-class vote counters are zero on entry.
- **VOTE:** lasts exactly K cycles, with index i=0..K-1, and `in_ready`=0.
  - If slot i is valid, counter[type_i] increments.
  - best_type and best_count are replaced when the incremented count is strictly greater than best_count. Among tied classes, the one that reached the maximum count first (nearest-first scan) wins.
  - After i=K-1, the state moves to RESULT.
- **RESULT:** outputs hold stable while `out_valid`=1.
  - On `out_valid` and `out_ready` both high: buffer, counters, sample counter and overflow clear, and the state returns to COLLECT.
  - On `clear`, in any state: same clearing and return to COLLECT, with no result emitted. `clear` has priority over a simultaneous input or output transfer.
- **Arithmetic:** comparisons are unsigned W-bit. The vote counters cannot overflow, because K < 2^width.

## Timing
- **Reset value of all outputs is 0**, except `in_ready`, which is 1 after reset deasserts.
- **Insertion latency:** a sample accepted at edge E is visible in the buffer after E.
- **Result latency:** with the last sample accepted at edge E0, VOTE occupies cycles E0..E0+K-1 and `out_valid` rises at edge E0+K.
- **Throughput:** `in_ready` falls at E0 and stays low until the edge after the result handshake. The query rate is one per N+K+1 cycles when `out_ready` is held high.
- **Back-pressure:** `out_ready`=0 holds RESULT indefinitely. No input is accepted meanwhile.
- **Fewer than K samples:** empty slots are skipped. `out_votes` may be below ceil(K/2).
- **Mid-operation reset:** `rst` asserted in any state clears everything asynchronously. `out_valid` drops immediately.

## Structure
- **Package `knn_pkg`:** state encoding (COLLECT/VOTE/RESULT), a `clog2` function, the derived count and vote widths, and the constant `DIST_INF`, which is all ones.
- **Sub-module `knn_topk_insert`:**
  - Holds the K-slot sorted shift-insert buffer: per-slot compare, shift enable and valid bits.
  - Has an insert strobe and a clear input.
  - Exposes its packed types, valid bits and slot 0 distance.
- **Top level:** owns the FSM, sample counter, overflow bit, vote counters and output registers.

## Test plan
- **Basic vote:** K=5, samples (d,t) = (40,1),(10,2),(30,2),(20,1),(50,3),(5,2) with last → out_type=2, out_votes=3, out_min_distance=5, overflow=0, and `out_valid` exactly K cycles after the last accept.
- **Distance tie ordering:** (10,1),(10,2),(10,3),(10,4),(10,5),(10,6) with K=5 → sample type 6 is discarded. The vote is a 1-1-1-1-1 tie, so out_type=1 and out_votes=1.
- **Short query:** two samples (7,4),(9,4) with last → out_type=4, out_votes=2, and empty slots ignored.
- **Overflow:** MAX_ELEMENTS=8, ten samples → out_overflow=1 and a correct vote. The next query reports overflow=0.
- **Back-pressure and clear:** hold `out_ready`=0 for 20 cycles → outputs stable and `in_ready`=0. Then pulse `clear` → `out_valid`=0 and `in_ready`=1 next cycle.
- **Async reset:** assert `rst` mid-VOTE → all outputs 0 immediately. After release, a fresh query produces the correct result.
